// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - multi-cycle bus sequencer for fetch, load/store and interrupt entry
module mem_seq #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       MemAck,
  input  logic       MemReq,
  input  logic       MemWrite,
  input  logic       ExecDone,
  input  logic       IntReq,
  input  logic       IntEnable,
  output logic       PcEn,
  output logic       PcWe,
  output logic       PcSelInt,
  output logic       IrWe,
  output logic       MemEn,
  output logic       LrWe,
  output logic       nOE,
  output logic       nWE,
  output logic       ExecGo,
  output logic       MemDone,
  output logic       IntTaken,
  output logic       Fault,
  output logic [2:0] Phase
);

  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);
  localparam logic [WW-1:0] WAIT_SAT  = {WW{1'b1}};

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_INT   = 3'd4,
    ST_FAULT = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          wr_q, wr_d;
  logic          exec_go_q, exec_go_d;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    exec_go_d = 1'b0;
    wait_d    = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;
    unique case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (MemAck) begin
          state_d   = ST_EXEC;
          exec_go_d = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_FAULT;
        end
      end
      ST_EXEC: begin
        // A simultaneous ExecDone is dropped; the decoder reasserts it after MEM.
        if (MemReq) begin
          state_d = ST_MEM;
          wr_d    = MemWrite;
        end else if (ExecDone) begin
          state_d = (IntReq && IntEnable) ? ST_INT : ST_FETCH;
        end
      end
      ST_MEM: begin
        if (MemAck) begin
          state_d = ST_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_FAULT;
        end
      end
      ST_INT:   state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= ST_RST;
      wait_q    <= '0;
      wr_q      <= 1'b0;
      exec_go_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      wr_q      <= wr_d;
      exec_go_q <= exec_go_d;
    end
  end

  // Strobes decode from state; only the capture strobes are qualified by MemAck.
  always_comb begin
    PcEn     = 1'b0;
    PcWe     = 1'b0;
    PcSelInt = 1'b0;
    IrWe     = 1'b0;
    MemEn    = 1'b0;
    LrWe     = 1'b0;
    nOE      = 1'b1;
    nWE      = 1'b1;
    MemDone  = 1'b0;
    IntTaken = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        PcEn  = 1'b1;
        nOE   = 1'b0;
        IrWe  = MemAck;
        MemEn = MemAck;
        PcWe  = MemAck;
      end
      ST_MEM: begin
        nOE     = wr_q;
        nWE     = !wr_q;
        MemDone = MemAck;
        MemEn   = MemAck && !wr_q;
      end
      ST_INT: begin
        LrWe     = 1'b1;
        PcWe     = 1'b1;
        PcSelInt = 1'b1;
        IntTaken = 1'b1;
      end
      default: ;
    endcase
  end

  assign ExecGo = exec_go_q && (state_q == ST_EXEC);
  assign Fault  = (state_q == ST_FAULT);
  assign Phase  = state_q;

endmodule
